alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter EN_MULDIV, default 1, 1 enables M-extension ops, 0 treats them as illegal.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port opcode  input  7  instruction opcode.
REQ-006 Port fun3  input  3  instruction funct3.
REQ-007 Port fun7  input  7  instruction funct7.
REQ-008 Port op_a  input  XLEN  operand A, rs1 value.
REQ-009 Port op_b  input  XLEN  operand B, rs2 value or sign-extended immediate.
REQ-010 Port in_valid  input  1  request present.
REQ-011 Port in_ready  output  1  unit can accept a request.
REQ-012 Port out_valid  output  1  result and illegal are valid.
REQ-013 Port out_ready  input  1  consumer takes the result.
REQ-014 Port result  output  XLEN  operation result.
REQ-015 Port illegal  output  1  request was not a supported op.

Function
REQ-016 Handshakes: a request is accepted on a cycle with in_valid and in_ready both high; a result is consumed on a cycle with out_valid and out_ready both high.
REQ-017 FSM states: IDLE, MUL_RUN, DIV_RUN, HOLD. in_ready is 1 only in IDLE; out_valid is 1 only in HOLD.
REQ-018 Accepted basic op: compute combinationally, register result, go to HOLD; out_valid rises in the cycle after acceptance (latency 1).
REQ-019 R-type (0110011), fun7=0000000:
- fun3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- fun7=0100000 with fun3 000 is SUB; with fun3 101 is SRA.
REQ-020 I-type (0010011): same fun3 map as R-type with op_b as the immediate; fun3 000 is always ADDI regardless of fun7.
REQ-021 I-type shifts: fun3 001 requires fun7=0000000; fun3 101 uses fun7=0000000 for SRLI and 0100000 for SRAI.
REQ-022 Shift amount is op_b[log2(XLEN)-1:0]; higher bits of op_b are ignored.
REQ-023 SLT/SLTU produce a result of 0 or 1, zero-extended to XLEN.
REQ-024 R-type with fun7=0000001 and EN_MULDIV=1 selects:
- fun3 000 MUL (low half), 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU (u×u) → MUL_RUN.
- fun3 100 DIV, 101 DIVU, 110 REM, 111 REMU → DIV_RUN.
REQ-025 MUL_RUN: iterative shift-add on magnitudes with sign fix-up; lasts exactly XLEN cycles, then HOLD; out_valid rises XLEN+1 cycles after acceptance.
REQ-026 DIV_RUN: restoring division on magnitudes, one quotient bit per cycle; identical fixed latency of XLEN+1 cycles, for all operand values.
REQ-027 Signed remainder takes the sign of the dividend; signed quotient is truncated toward zero.
REQ-028 Divide by zero: DIV/DIVU quotient is all ones; REM/REMU remainder is op_a.
REQ-029 Signed overflow (op_a = most negative value, op_b = −1): DIV result is op_a; REM result is 0.
REQ-030 Any other opcode/fun3/fun7 combination, or an M op with EN_MULDIV=0: take the latency-1 path with result 0 and illegal=1. For all legal ops illegal=0.
REQ-031 HOLD: result and illegal stay stable until consumed. On consumption the FSM returns to IDLE; the next accept is possible one cycle later (basic-op throughput 1 per 2 cycles).
REQ-032 Operands and op fields are captured at acceptance; input changes during RUN or HOLD have no effect.
REQ-033 out_ready while out_valid=0 has no effect; in_valid outside IDLE is ignored and not queued.

Reset
REQ-034 rst high at a clock edge forces IDLE, with result=0, illegal=0, out_valid=0, and the iteration counter and partial registers cleared; in_ready=1 in the cycle after reset.
REQ-035 Reset during MUL_RUN, DIV_RUN or HOLD aborts the operation with no result delivered; rst has priority over every handshake in the same cycle.

Verification
REQ-036 SUB, R-type, op_a=5, op_b=7, out_ready=1 → result=0xFFFFFFFE one cycle after accept, illegal=0.
REQ-037 SRAI, fun7=0100000, op_a=0x80000000, op_b=0x21 → result=0xC0000000 (shamt 1).
REQ-038 MULH, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → result=0 with out_valid exactly 33 cycles after accept; MULHU with the same operands → 0xFFFFFFFE.
REQ-039 DIV cases:
- op_a=7, op_b=0 → 0xFFFFFFFF; REM with the same operands → 7.
- DIV op_a=0x80000000, op_b=0xFFFFFFFF → 0x80000000.
- REM op_a=−7, op_b=2 → 0xFFFFFFFF.
REQ-040 opcode=0000011 → illegal=1, result=0; with out_ready held low for 5 cycles → out_valid and result stable and in_ready=0 throughout.
REQ-041 rst pulsed 10 cycles into a DIVU → out_valid never rises for that op, in_ready=1 the cycle after reset, and the next ADD completes correctly.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle RV base ALU ops plus iterative multiply
// and restoring divide, behind a one-deep valid/ready request/result handshake.
module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      fun3,
  input  logic [6:0]      fun7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. in_ready is
  // high only in IDLE and out_valid only in HOLD, so at most one op is in flight.

  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_M   = 7'b0000001;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, HOLD} state_t;

  state_t            state_q;
  logic [SHW-1:0]    cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              illegal_q;
  logic [2:0]        fun3_q;
  logic              neg_q;
  logic              div0_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   mul_hi_q, mul_lo_q, mcand_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvsr_q;

  logic [XLEN-1:0]   alu_res;
  logic              alu_ill, is_mul, is_div, base_ok, alt;
  logic [SHW-1:0]    shamt;

  // Decode and single-cycle datapath.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    base_ok = 1'b0;
    alt     = 1'b0;
    shamt   = op_b[SHW-1:0];
    if (opcode == OP_R && fun7 == F7_M) begin
      if (EN_MULDIV) begin
        is_mul = ~fun3[2];
        is_div = fun3[2];
      end else begin
        alu_ill = 1'b1;
      end
    end else if (opcode == OP_R) begin
      base_ok = (fun7 == F7_STD) ||
                (fun7 == F7_ALT && (fun3 == 3'b000 || fun3 == 3'b101));
      alt     = (fun7 == F7_ALT);
    end else if (opcode == OP_I) begin
      base_ok = !((fun3 == 3'b001 && fun7 != F7_STD) ||
                  (fun3 == 3'b101 && fun7 != F7_STD && fun7 != F7_ALT));
      alt     = (fun3 == 3'b101 && fun7 == F7_ALT);
    end
    if (!base_ok && !is_mul && !is_div) begin
      alu_ill = 1'b1;
    end
    if (base_ok) begin
      case (fun3)
        3'b000:  alu_res = alt ? (op_a - op_b) : (op_a + op_b);
        3'b001:  alu_res = op_a << shamt;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        3'b100:  alu_res = op_a ^ op_b;
        3'b101:  alu_res = alt ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
        3'b110:  alu_res = op_a | op_b;
        default: alu_res = op_a & op_b;
      endcase
    end
  end

  // Operand conditioning for the iterative units: magnitudes plus the sign of the result.
  logic            sgn_a, sgn_b, neg_a, neg_b, neg_d;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    neg_d = 1'b0;
    if (is_mul) begin
      sgn_a = (fun3[1:0] == 2'b01) || (fun3[1:0] == 2'b10);
      sgn_b = (fun3[1:0] == 2'b01);
    end else if (is_div) begin
      sgn_a = ~fun3[0];
      sgn_b = ~fun3[0];
    end
    neg_a = sgn_a & op_a[XLEN-1];
    neg_b = sgn_b & op_b[XLEN-1];
    abs_a = neg_a ? (-op_a) : op_a;
    abs_b = neg_b ? (-op_b) : op_b;
    // Quotient/MULH sign is the xor of operand signs; remainder/MULHSU follow op_a.
    if ((is_mul && fun3[1:0] == 2'b01) || (is_div && fun3[1:0] == 2'b00)) begin
      neg_d = neg_a ^ neg_b;
    end else if ((is_mul && fun3[1:0] == 2'b10) || (is_div && fun3[1:0] == 2'b10)) begin
      neg_d = neg_a;
    end
  end

  // One shift-add multiply step and one restoring divide step.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_d, mul_lo_d;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   mul_final;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   rem_d, quo_d, div_final;

  always_comb begin
    mul_sum   = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_hi_d  = mul_sum[XLEN:1];
    mul_lo_d  = {mul_sum[0], mul_lo_q[XLEN-1:1]};
    prod      = {mul_hi_d, mul_lo_d};
    prod_fix  = neg_q ? (-prod) : prod;
    mul_final = (fun3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvsr_q};
    if (!div_diff[XLEN]) begin
      rem_d = div_diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = div_shift[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
    if (!fun3_q[1]) begin
      div_final = div0_q ? {XLEN{1'b1}} : (neg_q ? (-quo_d) : quo_d);
    end else begin
      div_final = div0_q ? a_q : (neg_q ? (-rem_d) : rem_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      fun3_q    <= '0;
      neg_q     <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
      mul_hi_q  <= '0;
      mul_lo_q  <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            fun3_q <= fun3;
            neg_q  <= neg_d;
            div0_q <= (op_b == '0);
            a_q    <= op_a;
            cnt_q  <= '0;
            if (is_mul) begin
              mul_hi_q <= '0;
              mul_lo_q <= abs_b;
              mcand_q  <= abs_a;
              state_q  <= MUL_RUN;
            end else if (is_div) begin
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvsr_q  <= abs_b;
              state_q <= DIV_RUN;
            end else begin
              result_q  <= alu_res;
              illegal_q <= alu_ill;
              state_q   <= HOLD;
            end
          end
        end
        MUL_RUN: begin
          mul_hi_q <= mul_hi_d;
          mul_lo_q <= mul_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            result_q  <= mul_final;
            illegal_q <= 1'b0;
            state_q   <= HOLD;
          end
        end
        DIV_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            result_q  <= div_final;
            illegal_q <= 1'b0;
            state_q   <= HOLD;
          end
        end
        default: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign result      = result_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit: driver pushes model results into a queue,
// a monitor pops and compares on every consumed result and checks latency.
module tb_alu_exec_unit;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_M = 7'b0000001;
  localparam logic [6:0] F7_A = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  fun3 = '0;
  logic [6:0]  fun7 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, out_valid, illegal;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  logic [32:0] exp_q[$];
  int          due_q[$];
  int          cyc = 0;
  int          n_cmp = 0, n_fail = 0;
  int          rdy_mode = 1;

  alu_exec_unit #(.XLEN(32), .EN_MULDIV(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .fun3(fun3), .fun7(fun7),
    .op_a(op_a), .op_b(op_b), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: RV32IM semantics with 64-bit arithmetic.
  function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output int lat);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    logic [4:0]         sh;
    logic               alt, ok;
    sa = a; sb = b; sh = b[4:0];
    res = '0; ill = 1'b0; lat = 1; ok = 1'b0; alt = 1'b0; p = '0;
    if (opc == OP_R && f7 == F7_M) begin
      lat = 33;
      case (f3)
        3'd0: res = a * b;
        3'd1: begin p = longint'(sa) * longint'(sb); res = p[63:32]; end
        3'd2: begin p = longint'(sa) * longint'({32'd0, b}); res = p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; res = p[63:32]; end
        3'd4: res = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : $unsigned(sa / sb);
        3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: res = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : $unsigned(sa % sb);
        default: res = (b == 0) ? a : a % b;
      endcase
      return;
    end
    if (opc == OP_R) begin
      ok  = (f7 == 7'd0) || (f7 == F7_A && (f3 == 3'd0 || f3 == 3'd5));
      alt = (f7 == F7_A);
    end else if (opc == OP_I) begin
      if (f3 == 3'd1) ok = (f7 == 7'd0);
      else if (f3 == 3'd5) begin ok = (f7 == 7'd0 || f7 == F7_A); alt = (f7 == F7_A); end
      else ok = 1'b1;
    end
    if (!ok) begin
      ill = 1'b1;
      return;
    end
    case (f3)
      3'd0: res = alt ? a - b : a + b;
      3'd1: res = a << sh;
      3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: res = alt ? $unsigned(sa >>> sh) : a >> sh;
      3'd6: res = a | b;
      default: res = a & b;
    endcase
  endfunction

  // Driver: garbage inputs while busy, real request once in_ready is seen.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit push, input bit use_k, input logic [32:0] k);
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      in_valid = 1'($urandom_range(0, 1));
      opcode = 7'($urandom); fun3 = 3'($urandom); fun7 = 7'($urandom);
      op_a = $urandom; op_b = $urandom;
      guard++;
      if (guard > 200) begin
        in_valid = 1'b0;
        check("issue_timeout", 64'(in_ready), 64'd1);
        return;
      end
      @(negedge clk);
    end
    opcode = opc; fun3 = f3; fun7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
    model(opc, f3, f7, a, b, res, ill, lat);
    if (push) begin
      exp_q.push_back(use_k ? k : {ill, res});
      due_q.push_back(cyc + lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 7'($urandom); fun3 = 3'($urandom); fun7 = 7'($urandom);
    op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer ready pattern: 0 random, 1 always high, 2 held low.
  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0: out_ready = 1'($urandom_range(0, 1));
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard
  initial begin
    logic prev_ov;
    logic [32:0] e;
    int d;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (out_valid && !prev_ov) begin
          if (due_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            d = due_q.pop_front();
            check("latency", 64'(cyc), 64'(d));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", {31'd0, illegal, result}, {31'd0, e});
          end
        end
      end
      prev_ov = rst ? 1'b0 : out_valid;
    end
  end

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] opc, f7;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);

    rdy_mode = 1;
    issue(OP_R, 3'd0, F7_A, 32'd5, 32'd7, 1, 1, {1'b0, 32'hFFFF_FFFE});
    issue(OP_I, 3'd5, F7_A, 32'h8000_0000, 32'h21, 1, 1, {1'b0, 32'hC000_0000});
    issue(OP_R, 3'd1, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, {1'b0, 32'h0});
    issue(OP_R, 3'd3, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, {1'b0, 32'hFFFF_FFFE});
    issue(OP_R, 3'd4, F7_M, 32'd7, 32'd0, 1, 1, {1'b0, 32'hFFFF_FFFF});
    issue(OP_R, 3'd6, F7_M, 32'd7, 32'd0, 1, 1, {1'b0, 32'd7});
    issue(OP_R, 3'd4, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, {1'b0, 32'h8000_0000});
    issue(OP_R, 3'd6, F7_M, 32'hFFFF_FFF9, 32'd2, 1, 1, {1'b0, 32'hFFFF_FFFF});
    wait_drain(100);

    // Illegal opcode held in HOLD while the consumer stalls.
    rdy_mode = 2;
    @(negedge clk);
    issue(7'b0000011, 3'd2, 7'd0, $urandom, $urandom, 1, 1, {1'b1, 32'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_result", {31'd0, illegal, result}, {31'd0, 1'b1, 32'd0});
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    rdy_mode = 1;
    wait_drain(20);

    // Reset ten cycles into a DIVU: no result, unit ready right after.
    issue(OP_R, 3'd5, F7_M, 32'd1000, 32'd3, 0, 0, 33'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    repeat (40) @(negedge clk);
    issue(OP_R, 3'd0, 7'd0, 32'd1234, 32'd4321, 1, 1, {1'b0, 32'd5555});
    wait_drain(20);

    // Random traffic against the model with a random consumer.
    rdy_mode = 0;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: opc = OP_R;
        5, 6, 7, 8:    opc = OP_I;
        default:       opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0, 1:    f7 = 7'd0;
        2:       f7 = F7_A;
        3:       f7 = F7_M;
        default: f7 = 7'($urandom);
      endcase
      issue(opc, 3'($urandom), f7, rand_val(), rand_val(), 1, 0, 33'd0);
    end
    rdy_mode = 1;
    wait_drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
